pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Central pipeline hazard and sequencing controller for the 5-stage core. It generates hold and flush controls for the PC, if_id and id_ex registers from three sources: EX-stage jumps, ID/EX load-use hazards and multi-cycle data-bus accesses. A timeout guards bus waits. It replaces the scattered hold_flag generation with a single arbitrated source.

Parameters:
- TIMEOUT_CYCLES, 255: maximum MEM_WAIT cycles before abort. Legal range 2..65535.
- CNT_W, 16: width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk, input, 1: core clock.
- rst, input, 1: asynchronous, active-low reset.
- jump_en_i, input, 1: EX resolved a taken branch or jump.
- jump_addr_i, input, 32: target address.
- ex_is_load_i, input, 1: instruction in EX is a load.
- ex_rd_addr_i, input, 5: EX destination register.
- id_rs1_addr_i, input, 5: ID source register 1.
- id_rs2_addr_i, input, 5: ID source register 2.
- id_rs1_used_i, input, 1: rs1 is actually read by the ID instruction.
- id_rs2_used_i, input, 1: rs2 is actually read by the ID instruction.
- mem_req_i, input, 1: EX instruction issues a data-bus request.
- mem_ack_i, input, 1: bus completes the access.
- pc_jump_en_o, output, 1: load PC from jump_addr_o.
- jump_addr_o, output, 32: PC target.
- pc_hold_o, output, 1: freeze PC.
- if_id_hold_o, output, 1: freeze if_id.
- if_id_flush_o, output, 1: load NOP into if_id.
- id_ex_hold_o, output, 1: freeze id_ex.
- id_ex_flush_o, output, 1: load NOP or zero into id_ex.
- bus_err_o, output, 1: single-cycle pulse on wait timeout.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-low.
- Reset state:
  - state=S_RUN, wait_cnt=0.
  - All outputs 0, including jump_addr_o=0.
- All control outputs are combinational from the current state and inputs, giving zero-cycle latency. Only state and wait_cnt are registered.
- FSM states: S_RUN, S_MEM_WAIT, S_TIMEOUT.
- Priority within a cycle: jump > mem wait > load-use.
- Jump, in any state except S_MEM_WAIT:
  - Drive pc_jump_en_o=1, jump_addr_o=jump_addr_i, if_id_flush_o=1, id_ex_flush_o=1 for exactly that cycle.
  - No holds are asserted.
  - A simultaneous mem_req_i is illegal and is ignored.
- jump_addr_o outputs 0 whenever pc_jump_en_o=0.
- Load-use hazard, in S_RUN only:
  - Condition: ex_is_load_i && ex_rd_addr_i!=0 && ((id_rs1_used_i && rs1==rd) || (id_rs2_used_i && rs2==rd)).
  - Response: pc_hold_o=1, if_id_hold_o=1, id_ex_flush_o=1 for one cycle.
  - Because the bubble advances, the condition clears naturally on the next cycle.
- Mem wait:
  - In S_RUN, mem_req_i=1 with mem_ack_i=0:
    - Assert pc_hold, if_id_hold and id_ex_hold in the same cycle.
    - Next state is S_MEM_WAIT, wait_cnt=1.
  - mem_req_i with mem_ack_i=1 in the same cycle produces no stall.
  - In S_MEM_WAIT:
    - The three holds stay asserted while mem_ack_i=0, and wait_cnt increments.
    - On mem_ack_i=1, holds drop in that same cycle and the FSM returns to S_RUN with wait_cnt=0.
  - jump_en_i and load-use are ignored in S_MEM_WAIT because EX is frozen.
- Timeout:
  - In S_MEM_WAIT with mem_ack_i=0 and wait_cnt==TIMEOUT_CYCLES-1, the next state is S_TIMEOUT. Holds remain asserted this cycle.
  - S_TIMEOUT: bus_err_o=1 and id_ex_flush_o=1 (drops the faulting instruction), no holds. Unconditional return to S_RUN, wait_cnt=0.
  - A late mem_ack_i in S_TIMEOUT is ignored.
- Reset asserted mid-wait aborts immediately to S_RUN. All outputs drop asynchronously.
- hold and flush for the same register are never asserted together.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- When defined, two extra 32-bit outputs are added:
  - stall_cycles_o: counts cycles with pc_hold_o=1.
  - flush_events_o: counts cycles with id_ex_flush_o=1.
- Both reset to 0 and saturate at 0xFFFFFFFF.
- When undefined, the ports and counters are absent and there is no other change.

Decomposition:
- Shared defines file: state encodings CTRL_S_RUN=2'd0, CTRL_S_MEM_WAIT=2'd1, CTRL_S_TIMEOUT=2'd2, plus the existing INST_NOP used by flush targets.
- One natural sub-module, hazard_detect: the combinational load-use compare, output load_use_o.
- The FSM and counter stay in pipe_ctrl.

Test Plan:
- Reset: hold rst=0 with random inputs, release. All outputs are 0, and state=S_RUN after the first clk edge.
- Jump: jump_en_i=1, jump_addr_i=0x0000_0120 for one cycle. In that cycle pc_jump_en_o=1, jump_addr_o=0x120, both flushes=1, no holds. Next cycle all 0.
- Load-use:
  - ex_is_load_i=1, ex_rd=5, id_rs2=5, rs2_used=1 gives one cycle of pc_hold, if_id_hold and id_ex_flush.
  - Repeat with ex_rd=0, or rs2_used=0: no stall.
- Mem wait: mem_req_i=1, ack arrives after 3 cycles. Holds are high for exactly 3 cycles then drop in the ack cycle. A zero-wait ack gives no hold.
- Timeout: TIMEOUT_CYCLES=4, ack never arrives. Holds are high for 4 cycles, then one cycle of bus_err_o=1 with id_ex_flush_o=1, then S_RUN.
- Priority and reset: jump_en_i together with a load-use condition gives the jump response only. Assert rst at wait_cnt=2: outputs clear asynchronously, and after release a fresh request restarts the count at 1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
// Optional perf counters are enabled by defining PIPE_CTRL_PERF_EN.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_TIMEOUT  = 2'd2
    } ctrl_state_e;

    // Encoding the pipeline registers load on a flush (addi x0, x0, 0)
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Core-side hazard/bus signal bundle for pipe_ctrl.
// PIPE_CTRL_PERF_EN adds the two perf counter outputs.
interface pipe_ctrl_if;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        ex_is_load_i;
    logic [4:0]  ex_rd_addr_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic        id_rs1_used_i;
    logic        id_rs2_used_i;
    logic        mem_req_i;
    logic        mem_ack_i;
    logic        pc_jump_en_o;
    logic [31:0] jump_addr_o;
    logic        pc_hold_o;
    logic        if_id_hold_o;
    logic        if_id_flush_o;
    logic        id_ex_hold_o;
    logic        id_ex_flush_o;
    logic        bus_err_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_o;
    logic [31:0] flush_events_o;

    modport master (
        output jump_en_i, jump_addr_i, ex_is_load_i, ex_rd_addr_i,
               id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
               mem_req_i, mem_ack_i,
        input  pc_jump_en_o, jump_addr_o, pc_hold_o, if_id_hold_o,
               if_id_flush_o, id_ex_hold_o, id_ex_flush_o, bus_err_o,
               stall_cycles_o, flush_events_o
    );

    modport slave (
        input  jump_en_i, jump_addr_i, ex_is_load_i, ex_rd_addr_i,
               id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
               mem_req_i, mem_ack_i,
        output pc_jump_en_o, jump_addr_o, pc_hold_o, if_id_hold_o,
               if_id_flush_o, id_ex_hold_o, id_ex_flush_o, bus_err_o,
               stall_cycles_o, flush_events_o
    );
`else
    modport master (
        output jump_en_i, jump_addr_i, ex_is_load_i, ex_rd_addr_i,
               id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
               mem_req_i, mem_ack_i,
        input  pc_jump_en_o, jump_addr_o, pc_hold_o, if_id_hold_o,
               if_id_flush_o, id_ex_hold_o, id_ex_flush_o, bus_err_o
    );

    modport slave (
        input  jump_en_i, jump_addr_i, ex_is_load_i, ex_rd_addr_i,
               id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
               mem_req_i, mem_ack_i,
        output pc_jump_en_o, jump_addr_o, pc_hold_o, if_id_hold_o,
               if_id_flush_o, id_ex_hold_o, id_ex_flush_o, bus_err_o
    );
`endif
endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use compare between the load in EX and the sources read in ID.
module pipe_ctrl_hazard_detect (
    input  logic       ex_is_load_i,
    input  logic [4:0] ex_rd_addr_i,
    input  logic [4:0] id_rs1_addr_i,
    input  logic [4:0] id_rs2_addr_i,
    input  logic       id_rs1_used_i,
    input  logic       id_rs2_used_i,
    output logic       load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit    = id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i);
        rs2_hit    = id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i);
        // x0 is never a real dependency
        load_use_o = ex_is_load_i && (ex_rd_addr_i != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Arbitrated hold/flush source for PC, if_id and id_ex (jump > mem wait > load-use).
// Define PIPE_CTRL_PERF_EN for stall/flush perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input logic         clk,
    input logic         rst,
    pipe_ctrl_if.slave  bus
);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             load_use;

    logic        pc_jump_en;
    logic [31:0] jump_addr;
    logic        pc_hold;
    logic        if_id_hold;
    logic        if_id_flush;
    logic        id_ex_hold;
    logic        id_ex_flush;
    logic        bus_err;

    pipe_ctrl_hazard_detect u_hazard_detect (
        .ex_is_load_i  (bus.ex_is_load_i),
        .ex_rd_addr_i  (bus.ex_rd_addr_i),
        .id_rs1_addr_i (bus.id_rs1_addr_i),
        .id_rs2_addr_i (bus.id_rs2_addr_i),
        .id_rs1_used_i (bus.id_rs1_used_i),
        .id_rs2_used_i (bus.id_rs2_used_i),
        .load_use_o    (load_use)
    );

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        pc_jump_en  = 1'b0;
        jump_addr   = '0;
        pc_hold     = 1'b0;
        if_id_hold  = 1'b0;
        if_id_flush = 1'b0;
        id_ex_hold  = 1'b0;
        id_ex_flush = 1'b0;
        bus_err     = 1'b0;
        // Outputs are gated by reset so they drop asynchronously with it
        if (rst) begin
            unique case (state_q)
                S_RUN: begin
                    if (bus.jump_en_i) begin
                        pc_jump_en  = 1'b1;
                        jump_addr   = bus.jump_addr_i;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (bus.mem_req_i && !bus.mem_ack_i) begin
                        pc_hold    = 1'b1;
                        if_id_hold = 1'b1;
                        id_ex_hold = 1'b1;
                        state_d    = S_MEM_WAIT;
                        wait_cnt_d = CNT_W'(1);
                    end else if (load_use) begin
                        pc_hold     = 1'b1;
                        if_id_hold  = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                S_MEM_WAIT: begin
                    if (bus.mem_ack_i) begin
                        state_d    = S_RUN;
                        wait_cnt_d = '0;
                    end else begin
                        pc_hold    = 1'b1;
                        if_id_hold = 1'b1;
                        id_ex_hold = 1'b1;
                        if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            state_d    = S_TIMEOUT;
                            wait_cnt_d = '0;
                        end else begin
                            wait_cnt_d = wait_cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_TIMEOUT: begin
                    bus_err     = 1'b1;
                    id_ex_flush = 1'b1;
                    if (bus.jump_en_i) begin
                        pc_jump_en  = 1'b1;
                        jump_addr   = bus.jump_addr_i;
                        if_id_flush = 1'b1;
                    end
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                end
                default: begin
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign bus.pc_jump_en_o  = pc_jump_en;
    assign bus.jump_addr_o   = jump_addr;
    assign bus.pc_hold_o     = pc_hold;
    assign bus.if_id_hold_o  = if_id_hold;
    assign bus.if_id_flush_o = if_id_flush;
    assign bus.id_ex_hold_o  = id_ex_hold;
    assign bus.id_ex_flush_o = id_ex_flush;
    assign bus.bus_err_o     = bus_err;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_events_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= sat_inc32(stall_cycles_q, pc_hold);
            flush_events_q <= sat_inc32(flush_events_q, id_ex_flush);
        end
    end

    assign bus.stall_cycles_o = stall_cycles_q;
    assign bus.flush_events_o = flush_events_q;
`endif

endmodule
